// File: rtl/twdl_pkg.sv
// Shared types and constants for the mixed-radix FFT twiddle stage controller.
package twdl_pkg;

  localparam int TWDL_QBITS     = 20;
  localparam int BYPASS_DEMONTR = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIV,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } twdl_state_e;

  // Radices supported by the butterfly datapath.
  function automatic logic is_legal_factor(input logic [2:0] f);
    return f inside {3'd2, 3'd3, 3'd4, 3'd5};
  endfunction

endpackage

// File: rtl/twdl_recip_div.sv
// Sequential restoring divider: computes 2^Q_BITS / d, one quotient bit per
// cycle over Q_BITS+1 cycles. q1/r1 are valid in the cycle done is high.
module twdl_recip_div
  import twdl_pkg::*;
#(
  parameter int W_NUM  = 12,
  parameter int Q_BITS = TWDL_QBITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W_NUM-1:0]  demontr,
  output logic [Q_BITS-1:0] q1,
  output logic [W_NUM-1:0]  r1,
  output logic              done
);

  localparam int IDX_W = $clog2(Q_BITS + 1);

  logic              busy_q, busy_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [W_NUM-1:0]  rem_q, rem_d;
  logic [Q_BITS-1:0] quo_q, quo_d;
  logic [W_NUM-1:0]  dem_q, dem_d;

  logic [W_NUM:0]    trial;
  logic              trial_ge;
  logic [W_NUM:0]    trial_sub;
  logic [W_NUM-1:0]  rem_nx;
  logic [Q_BITS-1:0] quo_nx;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    // The dividend is a single 1 at bit Q_BITS; all lower bits are zero.
    trial     = {rem_q, (idx_q == IDX_W'(Q_BITS))};
    trial_ge  = (trial >= {1'b0, dem_q});
    trial_sub = trial - {1'b0, dem_q};
    rem_nx    = trial_ge ? trial_sub[W_NUM-1:0] : trial[W_NUM-1:0];
    quo_nx    = {quo_q[Q_BITS-2:0], trial_ge};

    busy_d = busy_q;
    idx_d  = idx_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dem_d  = dem_q;

    if (start) begin
      busy_d = 1'b1;
      idx_d  = IDX_W'(Q_BITS);
      rem_d  = '0;
      quo_d  = '0;
      dem_d  = demontr;
    end else if (busy_q) begin
      rem_d = rem_nx;
      quo_d = quo_nx;
      idx_d = idx_q - 1'b1;
      if (idx_q == '0) busy_d = 1'b0;
    end
  end

  assign done = busy_q && (idx_q == '0);
  assign q1   = quo_nx;
  assign r1   = rem_nx;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      idx_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dem_q  <= '0;
    end else begin
      busy_q <= busy_d;
      idx_q  <= idx_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dem_q  <= dem_d;
    end
  end

endmodule

// File: rtl/twdl_stage_seq.sv
// Per-stage controller for the CTA twiddle-multiply datapath: latches stage
// config, derives the unit twiddle step, issues butterflies and tracks returns.
module twdl_stage_seq
  import twdl_pkg::*;
#(
  parameter int wNum = 12,
  parameter int wQuo = TWDL_QBITS,
  parameter int wRem = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stg_start,
  input  logic [2:0]      cfg_factor,
  input  logic [wNum-1:0] cfg_demontr,
  input  logic [wNum-1:0] cfg_numrtr_max,
  input  logic [wNum-1:0] cfg_nbfly,
  input  logic            src_val,
  output logic            src_rdy,
  output logic            dp_in_val,
  output logic [2:0]      dp_factor,
  output logic [wNum-1:0] dp_numrtr,
  output logic [wNum-1:0] dp_demontr,
  output logic [wQuo-1:0] dp_quotient,
  output logic [wRem-1:0] dp_remainder,
  input  logic            dp_out_val,
  output logic            busy,
  output logic            stg_done,
  output logic            cfg_err
);

  twdl_state_e     state_q, state_d;
  logic [2:0]      fac_q, fac_d;
  logic [wNum-1:0] dem_q, dem_d;
  logic [wNum-1:0] nmax_q, nmax_d;
  logic [wNum-1:0] nbfly_q, nbfly_d;
  logic [wQuo-1:0] q1_q, q1_d;
  logic [wRem-1:0] r1_q, r1_d;
  logic [wNum-1:0] n_q, n_d;
  logic [wQuo-1:0] q_q, q_d;
  logic [wRem-1:0] r_q, r_d;
  logic [wNum-1:0] iss_cnt_q, iss_cnt_d;
  logic [wNum-1:0] out_cnt_q, out_cnt_d;
  logic            in_val_q, in_val_d;
  logic [wNum-1:0] numrtr_q, numrtr_d;
  logic [wQuo-1:0] quo_q, quo_d;
  logic [wRem-1:0] rem_q, rem_d;
  logic            cfg_err_q, cfg_err_d;

  logic            cfg_illegal;
  logic            accept;
  logic            div_start;
  logic            div_done;
  logic [wQuo-1:0] div_q1;
  logic [wNum-1:0] div_r1;
  logic [wNum:0]   iss_inc;
  logic [wRem:0]   r_sum;
  logic [wRem:0]   r_sub;
  logic            r_carry;

  twdl_recip_div #(
    .W_NUM  (wNum),
    .Q_BITS (wQuo)
  ) u_recip_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .demontr (cfg_demontr),
    .q1      (div_q1),
    .r1      (div_r1),
    .done    (div_done)
  );

  assign cfg_illegal = (cfg_demontr < wNum'(2)) || (cfg_nbfly == '0) ||
                       !is_legal_factor(cfg_factor);
  assign src_rdy     = (state_q == ST_RUN) && (iss_cnt_q != nbfly_q);
  assign accept      = src_val && src_rdy;
  assign iss_inc     = {1'b0, iss_cnt_q} + 1'b1;

  // Incremental twiddle step: (q, r) tracks floor/mod of n*2^20/D.
  assign r_sum   = {1'b0, r_q} + {1'b0, r1_q};
  assign r_carry = (r_sum >= (wRem+1)'(dem_q));
  assign r_sub   = r_sum - (wRem+1)'(dem_q);

  always_comb begin
    state_d   = state_q;
    fac_d     = fac_q;
    dem_d     = dem_q;
    nmax_d    = nmax_q;
    nbfly_d   = nbfly_q;
    q1_d      = q1_q;
    r1_d      = r1_q;
    n_d       = n_q;
    q_d       = q_q;
    r_d       = r_q;
    iss_cnt_d = iss_cnt_q;
    out_cnt_d = out_cnt_q;
    in_val_d  = 1'b0;
    numrtr_d  = numrtr_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cfg_err_d = 1'b0;
    div_start = 1'b0;

    // Returns beyond the stage's butterfly count are dropped.
    if ((state_q inside {ST_DIV, ST_RUN, ST_DRAIN}) && dp_out_val &&
        (out_cnt_q != nbfly_q)) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (stg_start) begin
          if (cfg_illegal) begin
            cfg_err_d = 1'b1;
          end else begin
            fac_d     = cfg_factor;
            dem_d     = cfg_demontr;
            nmax_d    = cfg_numrtr_max;
            nbfly_d   = cfg_nbfly;
            iss_cnt_d = '0;
            out_cnt_d = '0;
            n_d       = '0;
            q_d       = '0;
            r_d       = '0;
            if (cfg_demontr == wNum'(BYPASS_DEMONTR)) begin
              q1_d    = '0;
              r1_d    = '0;
              state_d = ST_RUN;
            end else begin
              div_start = 1'b1;
              state_d   = ST_DIV;
            end
          end
        end
      end

      ST_DIV: begin
        if (div_done) begin
          q1_d    = div_q1;
          r1_d    = wRem'(div_r1);
          n_d     = '0;
          q_d     = '0;
          r_d     = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (accept) begin
          in_val_d  = 1'b1;
          numrtr_d  = n_q;
          quo_d     = q_q;
          rem_d     = r_q;
          iss_cnt_d = iss_inc[wNum-1:0];
          if (n_q == nmax_q) begin
            n_d = '0;
            q_d = '0;
            r_d = '0;
          end else begin
            n_d = n_q + 1'b1;
            r_d = r_carry ? r_sub[wRem-1:0] : r_sum[wRem-1:0];
            q_d = q_q + q1_q + wQuo'(r_carry);
          end
          if (iss_inc == {1'b0, nbfly_q}) state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (out_cnt_q == nbfly_q) state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      fac_q     <= '0;
      dem_q     <= '0;
      nmax_q    <= '0;
      nbfly_q   <= '0;
      q1_q      <= '0;
      r1_q      <= '0;
      n_q       <= '0;
      q_q       <= '0;
      r_q       <= '0;
      iss_cnt_q <= '0;
      out_cnt_q <= '0;
      in_val_q  <= 1'b0;
      numrtr_q  <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fac_q     <= fac_d;
      dem_q     <= dem_d;
      nmax_q    <= nmax_d;
      nbfly_q   <= nbfly_d;
      q1_q      <= q1_d;
      r1_q      <= r1_d;
      n_q       <= n_d;
      q_q       <= q_d;
      r_q       <= r_d;
      iss_cnt_q <= iss_cnt_d;
      out_cnt_q <= out_cnt_d;
      in_val_q  <= in_val_d;
      numrtr_q  <= numrtr_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign dp_in_val    = in_val_q;
  assign dp_factor    = fac_q;
  assign dp_demontr   = dem_q;
  assign dp_numrtr    = numrtr_q;
  assign dp_quotient  = quo_q;
  assign dp_remainder = rem_q;
  assign busy         = (state_q != ST_IDLE);
  assign stg_done     = (state_q == ST_DONE);
  assign cfg_err      = cfg_err_q;

endmodule

// File: doc/twdl_stage_seq.md
Name: twdl_stage_seq

Overview:
- Per-stage controller for the CTA twiddle-multiply datapath in the mixed-radix (2/3/4/5) FFT.
- On a stage start it latches the stage configuration and computes the unit twiddle step floor(2^20/D) with a sequential restoring divider.
- It then issues one butterfly per accepted upstream beat, driving the twiddle datapath's in_val, factor, numerator, denominator, quotient and remainder.
- It counts datapath output beats and reports stage completion.

Parameters:
wNum, 12, width of numerator/denominator/count fields
wQuo, 20, width of twiddle quotient (fraction bits of n/D)
wRem, 12, width of twiddle remainder

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
stg_start  in  1  one-cycle pulse: latch cfg_* and begin stage
cfg_factor  in  3  radix of stage (2,3,4,5)
cfg_demontr  in  wNum  twiddle denominator D
cfg_numrtr_max  in  wNum  last numerator value before wrap (D/factor-1)
cfg_nbfly  in  wNum  butterflies in stage (>=1)
src_val  in  1  upstream butterfly data valid
src_rdy  out  1  controller accepts a butterfly this cycle
dp_in_val  out  1  to datapath in_val
dp_factor  out  3  to datapath factor
dp_numrtr  out  wNum  to datapath twdl_numrtr_1
dp_demontr  out  wNum  to datapath twdl_demontr
dp_quotient  out  wQuo  floor(n*2^20/D)
dp_remainder  out  wRem  n*2^20 mod D
dp_out_val  in  1  datapath out_val
busy  out  1  state != IDLE
stg_done  out  1  one-cycle pulse, stage complete
cfg_err  out  1  one-cycle pulse, illegal config rejected

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; internal counters, Q1, R1, n, q, r cleared.
- States: IDLE, DIV, RUN, DRAIN, DONE.
- IDLE:
  - stg_start with cfg_demontr<2, cfg_nbfly==0, or cfg_factor not in {2,3,4,5} -> cfg_err=1 next cycle, stay IDLE.
  - Legal stg_start: latch cfg; if D==3 -> RUN directly with Q1=R1=0 (datapath bypass mode); else -> DIV.
  - stg_start while busy is ignored.
- DIV:
  - Restoring division of 2^20 by D, one quotient bit per cycle, exactly 21 cycles; yields Q1 (20 b), R1 (<D).
  - Then clear n=q=r=0 and go to RUN.
- RUN:
  - src_rdy=1. A beat is accepted when src_val&src_rdy.
  - Accept at cycle t -> at t+1 dp_in_val=1 with dp_numrtr=n, dp_quotient=q, dp_remainder=r of that butterfly. Outputs are registered; dp_in_val=0 when no accept.
  - dp_factor and dp_demontr are held at the latched values from stage start until the next start.
  - Update after each accept:
    - if n==cfg_numrtr_max: n=q=r=0.
    - else: n+1; r'=r+R1; if r'>=D {r'-=D; carry=1}; q+=Q1+carry.
    - Invariant: q=floor(n*2^20/D), r=n*2^20 mod D.
  - After accept number cfg_nbfly: src_rdy drops the same cycle (combinational from issue count), go to DRAIN.
- DRAIN: count dp_out_val beats counted since stage start, including any during RUN. When the count reaches cfg_nbfly -> DONE. dp_out_val beyond cfg_nbfly is ignored.
- DONE: stg_done=1 for one cycle -> IDLE.
- Arithmetic: r+R1 is computed at wRem+1 bits; q wraps modulo 2^20 and never overflows for n<D.

Decomposition:
- Shared package twdl_pkg:
  - state enum.
  - constants TWDL_QBITS=20, BYPASS_DEMONTR=3.
  - legal factor set.
- Sub-module twdl_recip_div: sequential restoring divider.
  - Inputs: start, D.
  - Outputs: Q1, R1, done pulse after 21 cycles.
- Numerator/quotient accumulator and counters stay in the top module.

Test Plan:
- D=5, factor=5, numrtr_max=0, nbfly=3, src_val held high:
  - busy for 21 DIV cycles, then Q1=209715, R1=1.
  - 3 dp_in_val beats, all with n=0, q=0, r=0.
  - Return dp_out_val x3 -> stg_done pulse, then IDLE.
- D=12, factor=4, numrtr_max=2, nbfly=4:
  - Beats carry (n,q,r) = (0,0,0), (1,87381,4), (2,174762,8), (0,0,0).
  - Separate run with numrtr_max=3: fourth beat is (3,262144,0).
- D=3, factor=3, nbfly=2:
  - No DIV; RUN the cycle after start.
  - Two beats with q=r=0, dp_demontr=3.
- src_val toggling 1,0,1,1 in RUN, nbfly=3:
  - dp_in_val mirrors the accepts delayed by one cycle.
  - src_rdy=0 in the cycle after the third accept.
- Illegal configs: cfg_demontr=1 -> cfg_err pulse, busy stays 0; cfg_factor=6 -> cfg_err pulse.
- Reset and late start:
  - Assert rst mid-DIV and mid-RUN: all outputs 0 immediately, IDLE after release.
  - stg_start during RUN is ignored; the latched config is unchanged.
